// File: rtl/bus_pkg.sv
// bus_pkg: shared RamMode bit indices, bus IDs, load-pipe control struct and load extraction helper
package bus_pkg;
  localparam int unsigned RM_BYTE = 3;
  localparam int unsigned RM_HALF = 2;
  localparam int unsigned RM_WORD = 1;
  localparam int unsigned RM_UNS = 0;
  localparam int unsigned BUS_RAM = 0;
  localparam int unsigned BUS_UART = 1;
  typedef struct packed {
    logic valid;
    logic err;
    logic [1:0] lane;
    logic [2:0] width;
    logic uns;
  } ld_ctrl_t;
  function automatic logic [31:0] ld_extract(input logic [31:0] w, input logic [1:0] lane, input logic [2:0] width, input logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    return width[2] ? {{24{~uns & b[7]}}, b} : width[1] ? {{16{~uns & h[15]}}, h} : w;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 single-port RAM with byte write enables and registered read
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en_i) begin
      for (int b = 0; b < 4; b++) if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: RAM bus target serving core loads/stores with fixed RD_LAT load latency and error reporting
module data_mem_responder
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [31:0] addr,
  input  logic [31:0] dataBusOut,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [3:0]  RamMode,
  output logic [31:0] dataBusIn,
  output logic        dataBusInEn,
  output logic        accessErr
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned P = RD_LAT > 1 ? RD_LAT - 1 : 1;
  logic [31:0] off, wdata, rdata, last_data;
  logic [2:0] width;
  logic [3:0] be;
  logic req, err;
  ld_ctrl_t ctrl_d, last_ctrl;
  ld_ctrl_t ctrl_q [P];
  assign off = addr - BASE_ADDR;
  assign width = RamMode[RM_BYTE:RM_WORD];
  assign req = clkEn & (wrEn | rdEn);
  assign err = !$onehot(width) | (width[1] & off[0]) | (width[0] & |off[1:0])
             | ((off >> 2) >= 32'(DEPTH_WORDS)) | (wrEn & rdEn);
  assign be = width[2] ? 4'b0001 << off[1:0] : width[1] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = width[2] ? {4{dataBusOut[7:0]}} : width[1] ? {2{dataBusOut[15:0]}} : dataBusOut;
  assign ctrl_d = '{valid: req & rdEn, err: req & err, lane: off[1:0], width: width, uns: RamMode[RM_UNS]};
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk     (clk),
    .en_i    (req),
    .we_i    (req & wrEn & ~err ? be : 4'b0000),
    .addr_i  (off[AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );
  always_ff @(posedge clk)
    if (rst) ctrl_q <= '{default: '0};
    else begin
      ctrl_q[0] <= ctrl_d;
      for (int i = 1; i < P; i++) ctrl_q[i] <= ctrl_q[i-1];
    end
  assign last_ctrl = ctrl_q[P-1];
  if (P > 1) begin : g_dly
    logic [31:0] dly_q [P-1];
    always_ff @(posedge clk) begin
      dly_q[0] <= rdata;
      for (int i = 1; i < P - 1; i++) dly_q[i] <= dly_q[i-1];
    end
    assign last_data = dly_q[P-2];
  end else begin : g_nodly
    assign last_data = rdata;
  end
  if (RD_LAT > 1) begin : g_reg
    logic [31:0] dout_q;
    logic en_q, err_q;
    always_ff @(posedge clk)
      if (rst) begin
        dout_q <= '0;
        en_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        dout_q <= last_ctrl.valid ? (last_ctrl.err ? '0 : ld_extract(last_data, last_ctrl.lane, last_ctrl.width, last_ctrl.uns)) : dout_q;
        en_q <= last_ctrl.valid;
        err_q <= last_ctrl.err;
      end
    assign dataBusIn = dout_q;
    assign dataBusInEn = en_q;
    assign accessErr = err_q;
  end else begin : g_comb
    assign dataBusIn = last_ctrl.valid & ~last_ctrl.err ? ld_extract(last_data, last_ctrl.lane, last_ctrl.width, last_ctrl.uns) : '0;
    assign dataBusInEn = last_ctrl.valid;
    assign accessErr = last_ctrl.err;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a word-array model
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst, clkEn, wrEn, rdEn, dataBusInEn, accessErr;
  logic [31:0] addr, dataBusOut, dataBusIn;
  logic [3:0] RamMode;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [DEPTH];
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .addr        (addr),
    .dataBusOut  (dataBusOut),
    .wrEn        (wrEn),
    .rdEn        (rdEn),
    .RamMode     (RamMode),
    .dataBusIn   (dataBusIn),
    .dataBusInEn (dataBusInEn),
    .accessErr   (accessErr)
  );
  function automatic int size_of(input logic [3:0] m);
    return m[3] ? 1 : m[2] ? 2 : 4;
  endfunction
  function automatic bit model_err(input bit w, input bit r, input logic [31:0] a, input logic [3:0] m);
    logic [31:0] o;
    o = a - BASE;
    return ($countones(m[3:1]) != 1) || (o % size_of(m) != 0) || (o / 4 >= DEPTH) || (w && r);
  endfunction
  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] o, mask;
    int sh;
    o = a - BASE;
    sh = 8 * (o % 4);
    mask = size_of(m) == 4 ? 32'hFFFF_FFFF : ((32'd1 << (8 * size_of(m))) - 1) << sh;
    mem[o / 4] = (mem[o / 4] & ~mask) | ((d << sh) & mask);
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] o, v;
    o = a - BASE;
    v = mem[o / 4] >> (8 * (o % 4));
    if (size_of(m) == 1) begin
      v = v & 32'hFF;
      if (!m[0] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size_of(m) == 2) begin
      v = v & 32'hFFFF;
      if (!m[0] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic ce);
    wrEn = w;
    rdEn = r;
    addr = a;
    dataBusOut = d;
    RamMode = m;
    clkEn = ce;
    @(negedge clk);
    wrEn = 1'b0;
    rdEn = 1'b0;
    clkEn = 1'b1;
  endtask
  task automatic test_reset();
    checks++;
    if (dataBusIn !== 32'h0 || dataBusInEn !== 1'b0 || accessErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got data=%h en=%b err=%b expected data=0 en=0 err=0", dataBusIn, dataBusInEn, accessErr);
    end
  endtask
  task automatic test_word();
    access(1, 0, 32'h10, 32'hDEADBEEF, 4'b0010, 1);
    model_store(32'h10, 32'hDEADBEEF, 4'b0010);
    access(0, 1, 32'h10, 32'h0, 4'b0010, 1);
    checks++;
    if (dataBusInEn !== 1'b0) begin
      failures++;
      $display("FAIL word_load_early got en=%b expected en=0", dataBusInEn);
    end
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dataBusInEn !== 1'b1 || dataBusIn !== 32'hDEADBEEF || accessErr !== 1'b0) begin
      failures++;
      $display("FAIL word_load got en=%b data=%h err=%b expected en=1 data=deadbeef err=0", dataBusInEn, dataBusIn, accessErr);
    end
    @(negedge clk);
    checks++;
    if (dataBusInEn !== 1'b0 || dataBusIn !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_load_hold got en=%b data=%h expected en=0 data=deadbeef", dataBusInEn, dataBusIn);
    end
  endtask
  task automatic test_byte();
    logic [31:0] exp_s [4] = '{32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE};
    for (int i = 0; i < 4; i++) begin
      access(0, 1, 32'h10 + i, 32'h0, 4'b1000, 1);
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (dataBusInEn !== 1'b1 || dataBusIn !== exp_s[i]) begin
        failures++;
        $display("FAIL byte_signed_lane%0d got en=%b data=%h expected en=1 data=%h", i, dataBusInEn, dataBusIn, exp_s[i]);
      end
    end
    access(0, 1, 32'h13, 32'h0, 4'b1001, 1);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dataBusInEn !== 1'b1 || dataBusIn !== 32'h000000DE) begin
      failures++;
      $display("FAIL byte_unsigned got en=%b data=%h expected en=1 data=000000de", dataBusInEn, dataBusIn);
    end
  endtask
  task automatic test_half();
    logic [31:0] a [3] = '{32'h10, 32'h12, 32'h10};
    logic [3:0] m [3] = '{4'b0010, 4'b0100, 4'b0100};
    logic [31:0] e [3] = '{32'h1234BEEF, 32'h00001234, 32'hFFFFBEEF};
    access(1, 0, 32'h12, 32'hABCD1234, 4'b0100, 1);
    model_store(32'h12, 32'hABCD1234, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      access(0, 1, a[i], 32'h0, m[i], 1);
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (dataBusInEn !== 1'b1 || dataBusIn !== e[i]) begin
        failures++;
        $display("FAIL half_%0d got en=%b data=%h expected en=1 data=%h", i, dataBusInEn, dataBusIn, e[i]);
      end
    end
  endtask
  task automatic test_errors();
    logic [31:0] a [4] = '{32'h11, BASE + DEPTH * 4, 32'h10, 32'h10};
    logic [3:0] m [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      access(0, 1, a[i], 32'h0, m[i], 1);
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (accessErr !== 1'b1 || dataBusInEn !== 1'b1 || dataBusIn !== 32'h0) begin
        failures++;
        $display("FAIL err_load_%0d got err=%b en=%b data=%h expected err=1 en=1 data=0", i, accessErr, dataBusInEn, dataBusIn);
      end
      @(negedge clk);
      checks++;
      if (accessErr !== 1'b0) begin
        failures++;
        $display("FAIL err_pulse_%0d got err=%b expected err=0", i, accessErr);
      end
    end
    access(1, 0, 32'h13, 32'h0, 4'b0010, 1);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (accessErr !== 1'b1 || dataBusInEn !== 1'b0) begin
      failures++;
      $display("FAIL err_store got err=%b en=%b expected err=1 en=0", accessErr, dataBusInEn);
    end
    access(1, 1, 32'h10, 32'h0, 4'b0010, 1);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (accessErr !== 1'b1 || dataBusInEn !== 1'b1 || dataBusIn !== 32'h0) begin
      failures++;
      $display("FAIL err_both got err=%b en=%b data=%h expected err=1 en=1 data=0", accessErr, dataBusInEn, dataBusIn);
    end
    access(0, 1, 32'h10, 32'h0, 4'b0010, 1);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dataBusIn !== model_load(32'h10, 4'b0010)) begin
      failures++;
      $display("FAIL err_ram_unchanged got data=%h expected data=%h", dataBusIn, model_load(32'h10, 4'b0010));
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] e [3];
    access(1, 0, 32'h14, 32'h5555AAAA, 4'b0010, 1);
    model_store(32'h14, 32'h5555AAAA, 4'b0010);
    access(1, 0, 32'h18, 32'h01234567, 4'b0010, 1);
    model_store(32'h18, 32'h01234567, 4'b0010);
    for (int i = 0; i < 3; i++) e[i] = model_load(32'h10 + 4 * i, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      rdEn = i < 3;
      addr = 32'h10 + 4 * i;
      RamMode = 4'b0010;
      clkEn = 1'b1;
      @(negedge clk);
      if (i >= 1 && i <= 3) begin
        checks++;
        if (dataBusInEn !== 1'b1 || dataBusIn !== e[i-1]) begin
          failures++;
          $display("FAIL b2b_%0d got en=%b data=%h expected en=1 data=%h", i - 1, dataBusInEn, dataBusIn, e[i-1]);
        end
      end
    end
    rdEn = 1'b0;
    checks++;
    if (dataBusInEn !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got en=%b expected en=0", dataBusInEn);
    end
  endtask
  task automatic test_raw();
    logic [31:0] v;
    v = $urandom;
    wrEn = 1'b1;
    addr = 32'h14;
    dataBusOut = v;
    RamMode = 4'b0010;
    @(negedge clk);
    model_store(32'h14, v, 4'b0010);
    access(0, 1, 32'h14, 32'h0, 4'b0010, 1);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dataBusInEn !== 1'b1 || dataBusIn !== v) begin
      failures++;
      $display("FAIL raw got en=%b data=%h expected en=1 data=%h", dataBusInEn, dataBusIn, v);
    end
  endtask
  task automatic test_reset_inflight();
    rdEn = 1'b1;
    addr = 32'h10;
    RamMode = 4'b0010;
    @(negedge clk);
    rdEn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dataBusInEn !== 1'b0 || dataBusIn !== 32'h0 || accessErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_inflight got en=%b data=%h err=%b expected en=0 data=0 err=0", dataBusInEn, dataBusIn, accessErr);
    end
    @(negedge clk);
    checks++;
    if (dataBusInEn !== 1'b0) begin
      failures++;
      $display("FAIL reset_inflight_after got en=%b expected en=0", dataBusInEn);
    end
  endtask
  task automatic test_clken();
    access(0, 1, 32'h10, 32'h0, 4'b0010, 0);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dataBusInEn !== 1'b0 || accessErr !== 1'b0) begin
      failures++;
      $display("FAIL clken_load got en=%b err=%b expected en=0 err=0", dataBusInEn, accessErr);
    end
    access(1, 0, 32'h10, 32'hFFFFFFFF, 4'b0010, 0);
    access(0, 1, 32'h10, 32'h0, 4'b0010, 1);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dataBusIn !== model_load(32'h10, 4'b0010)) begin
      failures++;
      $display("FAIL clken_store got data=%h expected data=%h", dataBusIn, model_load(32'h10, 4'b0010));
    end
  endtask
  task automatic test_random();
    logic [3:0] modes [6] = '{4'b1000, 4'b1001, 4'b0100, 4'b0101, 4'b0010, 4'b0011};
    logic [31:0] a, d, ed;
    logic [3:0] m;
    bit w, r, ee;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      access(1, 0, 32'h100 + 4 * i, d, 4'b0010, 1);
      model_store(32'h100 + 4 * i, d, 4'b0010);
    end
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: begin w = 1; r = 1; end
        1, 2, 3, 4: begin w = 1; r = 0; end
        default: begin w = 0; r = 1; end
      endcase
      m = $urandom_range(0, 15) == 0 ? 4'($urandom) : modes[$urandom_range(0, 5)];
      a = $urandom_range(0, 20) == 0 ? BASE + DEPTH * 4 + $urandom_range(0, 64) : 32'h100 + $urandom_range(0, 63);
      d = $urandom;
      ee = model_err(w, r, a, m);
      ed = (r && !ee) ? model_load(a, m) : 32'h0;
      if (w && !ee) model_store(a, d, m);
      access(w, r, a, d, m, 1);
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (accessErr !== ee || dataBusInEn !== r || (r && dataBusIn !== ed)) begin
        failures++;
        $display("FAIL random_%0d a=%h m=%b w=%b r=%b got err=%b en=%b data=%h expected err=%b en=%b data=%h",
                 i, a, m, w, r, accessErr, dataBusInEn, dataBusIn, ee, r, ed);
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    clkEn = 1'b1;
    wrEn = 1'b0;
    rdEn = 1'b0;
    addr = '0;
    dataBusOut = '0;
    RamMode = 4'b0010;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_raw();
    test_reset_inflight();
    test_clken();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Bus responder (target side) for the RV32I core's data port: accepts load/store requests on addr/dataBusOut/wrEn/rdEn/RamMode and returns load data on dataBusIn with the dataBusInEn strobe.
- Contains word-organised data RAM with byte-lane writes, sub-word load extraction and sign/zero extension.
- Load data timing matches the core's writeback slot: fixed latency of RD_LAT cycles after the request.
- Sits between the core and the top-level bus decode, serving the RAM bus ID region.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the data RAM (power of two).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
RD_LAT, 2, cycles from request edge to dataBusIn valid; legal 1..3.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
clkEn  input  1  request qualifier; requests sampled only when high.
addr  input  32  byte address from the core.
dataBusOut  input  32  store data from the core; byte/half taken from the low bits.
wrEn  input  1  store request.
rdEn  input  1  load request.
RamMode  input  4  {byte, half, word, unsigned}.
dataBusIn  output  32  load data to the core, already extended.
dataBusInEn  output  1  one-cycle strobe marking dataBusIn valid.
accessErr  output  1  one-cycle pulse for a rejected request, aligned with the request's response slot.

Behaviour:
- Reset, synchronous active-high: dataBusIn=0, dataBusInEn=0, accessErr=0, all latency-pipe valid bits cleared. RAM contents are not cleared; an in-flight load at reset is discarded.
- Request accepted at a rising edge when clkEn=1 and (wrEn|rdEn). With clkEn=0, the request is ignored; the latency pipe still advances.
- Width select: exactly one of RamMode[3:1] must be set. Zero or multiple set is an error.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Violation is an error.
- Range: (addr-BASE_ADDR) >> 2 must be < DEPTH_WORDS. Otherwise error.
- wrEn and rdEn both high is an error; neither side takes effect.
- Error handling:
  - Write dropped, RAM unchanged.
  - If rdEn is set, the response slot still asserts dataBusInEn with dataBusIn=0.
  - accessErr pulses in the same slot as the response. For a write-only request, that slot is RD_LAT cycles later.
- Store: commits at the accepting edge. Byte enables:
  - byte: lane addr[1:0], data dataBusOut[7:0].
  - half: lanes {addr[1],0}, data dataBusOut[15:0].
  - word: all lanes.
- Load: RAM read is synchronous at the accepting edge. Lane/width/unsigned/error info travels RD_LAT-1 further register stages alongside it. Extraction and extension are registered into dataBusIn:
  - byte: lane addr[1:0], sign- or zero-extended from bit 7.
  - half: addr[1] selects the halfword, extended from bit 15.
  - word: passed through.
- Latency: load accepted at edge N → dataBusIn/dataBusInEn valid for the cycle following edge N+RD_LAT-1. For RD_LAT=2, that is the cycle after edge N+1. Back-to-back loads every cycle are supported, with one response per cycle in order.
- Read-after-write: a store at edge N followed by a load of the same word at edge N+1 returns the new data. A load and a store in the same cycle cannot occur, since that case is an error.
- dataBusIn holds its last value when dataBusInEn=0. Consumers must qualify with dataBusInEn.
- No backpressure and no busy signal; the responder always accepts.

Decomposition:
- Shared package bus_pkg holds:
  - RamMode bit indices: RM_BYTE=3, RM_HALF=2, RM_WORD=1, RM_UNS=0.
  - Bus ID constants BUS_RAM=0, BUS_UART=1.
  - Struct typedef ld_ctrl_t {valid, err, lane[1:0], width one-hot[2:0], uns}, used for the latency pipe.
- One sub-module, dmem_array: DEPTH_WORDS x 32 single-port RAM with 4 byte write enables and synchronous read, inferable as block RAM.

Test Plan:
- Word store 32'hDEADBEEF to 0x10 (RamMode 4'b0010), then word load 0x10 → dataBusInEn high 2 cycles later, dataBusIn=32'hDEADBEEF.
- Byte loads from 0x10, lanes 0..3:
  - signed → 32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE.
  - lane 3 unsigned (RamMode 4'b1001) → 32'h000000DE.
- Half store 16'h1234 to 0x12, then word load 0x10 → 32'h1234BEEF. Half load 0x12 signed → 32'h00001234. Half load 0x10 signed → 32'hFFFFBEEF.
- Misaligned word load at 0x11 → accessErr pulse, dataBusIn=0, dataBusInEn=1. Misaligned word store at 0x13 → RAM unchanged and accessErr pulse.
- Back-to-back loads 0x10, 0x14, 0x18 on consecutive cycles → three consecutive dataBusInEn cycles with data in order. A store to 0x14 one cycle before its load returns the new value.
- Reset asserted the cycle after a load → no dataBusInEn, outputs 0. Load with clkEn=0 → no response. Address BASE_ADDR+DEPTH_WORDS*4 → accessErr.
